// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer
//   Fades red, green and blue LEDs in turn. Each colour ramps its PWM duty
//   up by STEP per tick until full brightness, holds there for HOLD_TICKS
//   ticks, ramps back down to zero, then hands over to the next colour.
//   The PWM duty only changes on a PWM period boundary, so an LED never sees
//   a shortened or stretched pulse in the middle of a period.
//
//   Optional feature: define RGB_LED_SEQUENCER_GAMMA_EN to compare the PWM
//   counter against (duty_active*duty_active) >> PWM_BITS instead of the
//   linear duty_active. Sequencing timing is the same in both builds.
//
// Parameters
//   PWM_BITS   width of the PWM counter and duty registers
//   STEP       duty change applied per tick while ramping
//   HOLD_TICKS ticks spent at full brightness
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   enable     sequencer runs while high; low returns everything to idle
//   tick       one-clk step pulse (held high for N clks counts as N ticks)
//   nLED_RED   active-low red drive
//   nLED_GRN   active-low green drive
//   nLED_BLU   active-low blue drive
//   color      active colour: 0=red, 1=green, 2=blue (3 never occurs)
//   cycle_done one-clk pulse when blue finishes ramping down (colour wraps)
//   fsm_state  debug view of the sequencer state (0=IDLE, 1=RAMP_UP,
//              2=HOLD, 3=RAMP_DOWN)

module rgb_led_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 8,
    parameter int HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    output logic       nLED_RED,
    output logic       nLED_GRN,
    output logic       nLED_BLU,
    output logic [1:0] color,
    output logic       cycle_done,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t              state, state_n;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty, duty_n;
    logic [PWM_BITS-1:0] duty_active;
    logic [1:0]          color_n;
    logic [HW-1:0]       hold_cnt, hold_n;
    logic                done_n;

    // One bit wider so a step past full scale is seen as overflow.
    logic [PWM_BITS:0]   duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    logic [PWM_BITS-1:0] cmp_val;
    logic                pwm_on;

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            duty       <= '0;
            color      <= 2'd0;
            hold_cnt   <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_n;
            duty       <= duty_n;
            color      <= color_n;
            hold_cnt   <= hold_n;
            cycle_done <= done_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The first enabled clk out of IDLE only starts the
    // ramp; a tick arriving in that same clk is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        duty_n  = duty;
        color_n = color;
        hold_n  = hold_cnt;
        done_n  = 1'b0;
        duty_up = {1'b0, duty} + STEP_W;
        duty_dn = duty - STEP_N;

        if (!enable) begin
            state_n = IDLE;
            duty_n  = '0;
            color_n = 2'd0;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = RAMP_UP;
                end
                RAMP_UP: begin
                    if (tick) begin
                        if (duty_up >= {1'b0, DUTY_MAX}) begin
                            duty_n  = DUTY_MAX;
                            state_n = HOLD;
                        end else begin
                            duty_n = duty_up[PWM_BITS-1:0];
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_n  = '0;
                            state_n = RAMP_DOWN;
                        end else begin
                            hold_n = hold_cnt + HW'(1);
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        // Clamp at zero instead of wrapping below it.
                        if ({1'b0, duty} <= STEP_W) begin
                            duty_n  = '0;
                            state_n = RAMP_UP;
                            if (color == 2'd2) begin
                                color_n = 2'd0;
                                done_n  = 1'b1;
                            end else begin
                                color_n = color + 2'd1;
                            end
                        end else begin
                            duty_n = duty_dn;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PWM counter and period-aligned duty latch. duty_active picks up the
    // working duty only on the last count of a period, so the new value
    // takes effect from count 0 of the following period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt     <= '0;
            duty_active <= '0;
        end else if (!enable) begin
            pwm_cnt     <= '0;
            duty_active <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == DUTY_MAX) begin
                duty_active <= duty;
            end
        end
    end

`ifdef RGB_LED_SEQUENCER_GAMMA_EN
    // Square-law brightness: upper half of the full-width self-product.
    logic [2*PWM_BITS-1:0] gamma_prod;
    assign gamma_prod = {{PWM_BITS{1'b0}}, duty_active} * {{PWM_BITS{1'b0}}, duty_active};
    assign cmp_val    = gamma_prod[2*PWM_BITS-1:PWM_BITS];
`else
    assign cmp_val = duty_active;
`endif

    // duty_active is zero in reset and idle, so every LED sits high there.
    assign pwm_on    = (pwm_cnt < cmp_val);
    assign nLED_RED  = ~(pwm_on && (color == 2'd0));
    assign nLED_GRN  = ~(pwm_on && (color == 2'd1));
    assign nLED_BLU  = ~(pwm_on && (color == 2'd2));
    assign fsm_state = state;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer with PWM_BITS=4, STEP=4, HOLD_TICKS=2.
// A reference model describes each colour as a list of duty levels, one per
// tick, built from the ramp/hold rules; it is compared with the DUT on every
// clock. Directed sections pin the model with hand-computed values.

module tb_rgb_led_sequencer;

    localparam int PB   = 4;
    localparam int STP  = 4;
    localparam int HT   = 2;
    localparam int MAXV = (1 << PB) - 1;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       tick;
    logic       nLED_RED;
    logic       nLED_GRN;
    logic       nLED_BLU;
    logic [1:0] color;
    logic       cycle_done;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_led_sequencer #(
        .PWM_BITS  (PB),
        .STEP      (STP),
        .HOLD_TICKS(HT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tick      (tick),
        .nLED_RED  (nLED_RED),
        .nLED_GRN  (nLED_GRN),
        .nLED_BLU  (nLED_BLU),
        .color     (color),
        .cycle_done(cycle_done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Duty level after each tick of one colour's up/hold/down journey.
    int seq[$];

    int m_active = 0;
    int m_color  = 0;
    int m_idx    = 0;
    int m_duty   = 0;
    int m_dact   = 0;
    int m_cnt    = 0;
    int m_done   = 0;

    function automatic int cmp_of(input int d);
`ifdef RGB_LED_SEQUENCER_GAMMA_EN
        return (d * d) >> PB;
`else
        return d;
`endif
    endfunction

    task automatic build_seq();
        int d;
        d = 0;
        seq.delete();
        while (d < MAXV) begin
            d = (d + STP > MAXV) ? MAXV : d + STP;
            seq.push_back(d);
        end
        for (int i = 0; i < HT; i++) seq.push_back(MAXV);
        while (d > 0) begin
            d = (d > STP) ? d - STP : 0;
            seq.push_back(d);
        end
    endtask

    always @(posedge clk) begin
        if (!rst || !enable) begin
            m_active = 0; m_color = 0; m_idx = 0; m_duty = 0;
            m_dact = 0; m_cnt = 0; m_done = 0;
        end else begin
            if (m_cnt == MAXV) m_dact = m_duty;
            m_cnt  = (m_cnt + 1) % (MAXV + 1);
            m_done = 0;
            if (m_active == 0) begin
                m_active = 1;
            end else if (tick) begin
                m_duty = seq[m_idx];
                m_idx++;
                if (m_idx == seq.size()) begin
                    m_idx = 0;
                    if (m_color == 2) m_done = 1;
                    m_color = (m_color + 1) % 3;
                end
            end
        end
        #1;
        begin
            bit on;
            on = (m_cnt < cmp_of(m_dact));
            check("nLED_RED", int'(nLED_RED), (on && m_color == 0) ? 0 : 1);
            check("nLED_GRN", int'(nLED_GRN), (on && m_color == 1) ? 0 : 1);
            check("nLED_BLU", int'(nLED_BLU), (on && m_color == 2) ? 0 : 1);
            check("color", int'(color), m_color);
            check("cycle_done", int'(cycle_done), m_done);
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input bit en, input bit tk);
        @(negedge clk);
        enable = en;
        tick   = tk;
        @(posedge clk);
        #2;
    endtask

`ifdef RGB_LED_SEQUENCER_GAMMA_EN
    int exp_low[10] = '{1, 4, 9, 14, 14, 14, 7, 3, 0, 0};
    localparam int EXP_DUTY4_2P = 2;
`else
    int exp_low[10] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0};
    localparam int EXP_DUTY4_2P = 8;
`endif
    int exp_seq[10] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0};

    // ---------------- stimulus ----------------
    initial begin
        int low_cnt[10];
        int k;
        int done_cnt;
        int lows;
        bit seen;

        rst = 1'b0; enable = 1'b0; tick = 1'b0;
        build_seq();
        check("seq_len", seq.size(), 10);
        for (int i = 0; i < 10; i++) check("seq_val", seq[i], exp_seq[i]);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_red", int'(nLED_RED), 1);
        check("rst_grn", int'(nLED_GRN), 1);
        check("rst_blu", int'(nLED_BLU), 1);
        check("rst_color", int'(color), 0);
        check("rst_done", int'(cycle_done), 0);
        check("rst_state", int'(fsm_state), 0);
        @(negedge clk) rst = 1'b1;
        cyc(0, 0);
        cyc(0, 0);

        // One red ramp, a tick every 16 clks landing mid PWM period; the
        // on-time of each period reflects the duty latched at its start.
        for (int i = 0; i < 10; i++) low_cnt[i] = 0;
        for (int e = 0; e < 176; e++) begin
            cyc(1, (e % 16 == 7) && (e < 160));
            if (e >= 15 && e < 175) low_cnt[(e - 15) / 16] += (nLED_RED == 1'b0) ? 1 : 0;
        end
        for (int p = 0; p < 10; p++) check("period_low_red", low_cnt[p], exp_low[p]);
        check("color_after_red", int'(color), 1);

        // Finish green and blue with tick held high: 20 ticks to the wrap.
        k = 0; seen = 1'b0; done_cnt = 0;
        while (!seen && k < 60) begin
            cyc(1, 1);
            k++;
            if (cycle_done) begin
                seen = 1'b1;
                done_cnt++;
                check("color_at_wrap", int'(color), 0);
            end
            if (color == 2'd3) check("color_not_3", int'(color), 0);
        end
        check("ticks_to_wrap", k, 20);
        check("wrap_seen", int'(seen), 1);
        cyc(1, 0);
        check("done_one_clk", int'(cycle_done), 0);

        // Enable dropped while green is ramping down.
        repeat (17) cyc(1, 1);
        check("pre_drop_state", int'(fsm_state), 3);
        check("pre_drop_color", int'(color), 1);
        cyc(0, 0);
        check("drop_red", int'(nLED_RED), 1);
        check("drop_grn", int'(nLED_GRN), 1);
        check("drop_blu", int'(nLED_BLU), 1);
        check("drop_color", int'(color), 0);
        check("drop_state", int'(fsm_state), 0);
        cyc(1, 0);
        check("reen_state", int'(fsm_state), 1);
        check("reen_color", int'(color), 0);
        lows = 0;
        repeat (20) begin
            cyc(1, 0);
            lows += (nLED_RED == 1'b0) ? 1 : 0;
        end
        check("reen_duty0_lows", lows, 0);

        // Asynchronous reset in the middle of HOLD while red is lit.
        repeat (5) cyc(1, 1);
        check("hold_state", int'(fsm_state), 2);
        repeat (20) cyc(1, 0);
        k = 0;
        cyc(1, 0);
        while (nLED_RED && k < 16) begin
            cyc(1, 0);
            k++;
        end
        check("red_lit_before_rst", int'(nLED_RED), 0);
        rst = 1'b0;
        #1;
        check("arst_red", int'(nLED_RED), 1);
        check("arst_grn", int'(nLED_GRN), 1);
        check("arst_blu", int'(nLED_BLU), 1);
        check("arst_color", int'(color), 0);
        check("arst_done", int'(cycle_done), 0);
        check("arst_state", int'(fsm_state), 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        cyc(1, 0);
        check("post_rst_state", int'(fsm_state), 1);
        cyc(1, 1);
        repeat (17) cyc(1, 0);
        lows = 0;
        repeat (32) begin
            cyc(1, 0);
            lows += (nLED_RED == 1'b0) ? 1 : 0;
        end
        check("post_rst_duty4", lows, EXP_DUTY4_2P);

        // Randomised run checked by the model every clock.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 799) != 0);
            enable = ($urandom_range(0, 399) != 0);
            tick   = ($urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        rst = 1'b1; enable = 1'b0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/rgb_led_sequencer.md
RGB_LED_SEQUENCER -- requirements
Module: rgb_led_sequencer

Interface
REQ-001 The module SHALL have parameter PWM_BITS, default 8: width of PWM counter and duty register.
REQ-002 The module SHALL have parameter STEP, default 8: duty increment/decrement applied per tick.
REQ-003 The module SHALL have parameter HOLD_TICKS, default 4: ticks spent at full brightness.
REQ-004 The module SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port enable, input, 1 bit: run sequencer when high.
REQ-007 The module SHALL have port tick, input, 1 bit: one-clk step pulse from the upstream Hz clock divider's dividedPulse.
REQ-008 The module SHALL have ports nLED_RED, nLED_GRN and nLED_BLU, each output, 1 bit: active-low LED drives.
REQ-009 The module SHALL have port color, output, 2 bits: active colour, 0=RED, 1=GRN, 2=BLU.
REQ-010 The module SHALL have port cycle_done, output, 1 bit: one-clk pulse when BLU completes its ramp-down.

Function
REQ-011 pwm_cnt (PWM_BITS) SHALL increment every clk while enable=1 and wrap from 2^PWM_BITS-1 to 0; held at 0 when enable=0.
REQ-012 duty_active SHALL load from duty only in the cycle pwm_cnt==2^PWM_BITS-1, so there is no mid-period glitch.
REQ-013 The selected LED SHALL be driven low exactly when pwm_cnt < duty_active; unselected LEDs SHALL be high; duty_active=0 SHALL give 0% on-time; with duty_active=max the LED SHALL be low for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
REQ-014 The FSM SHALL have states IDLE, RAMP_UP, HOLD and RAMP_DOWN.
REQ-015 IDLE->RAMP_UP SHALL occur on the first clk with enable=1; a tick in that same cycle SHALL be ignored.
REQ-016 In RAMP_UP, on tick: duty=min(duty+STEP, max), computed one bit wider to detect overflow; duty reaching max SHALL transition to HOLD.
REQ-017 In HOLD, on tick: the hold counter SHALL increment; the HOLD_TICKS-th tick SHALL transition to RAMP_DOWN and clear the counter.
REQ-018 In RAMP_DOWN, on tick: duty=max(duty-STEP, 0) without underflow; duty reaching 0 SHALL advance color (0->1->2->0) and transition to RAMP_UP.
REQ-019 cycle_done SHALL be high exactly one clk, the cycle color wraps 2->0.
REQ-020 Any enable=0 SHALL move to IDLE next clk, with duty=0, duty_active=0, color=0, hold counter=0 and all LEDs high.
REQ-021 Ticks SHALL be ignored in IDLE; tick held high for N clks SHALL count as N ticks.
REQ-022 color SHALL never take value 3.

Reset
REQ-023 While rst=0, the module SHALL immediately set state=IDLE, pwm_cnt=0, duty=0, duty_active=0, color=0, hold counter=0 and cycle_done=0, and drive nLED_RED, nLED_GRN and nLED_BLU to 1.
REQ-024 Reset release SHALL be taken synchronously; the first active edge after release SHALL behave as IDLE with the current enable.
REQ-025 Reset asserted mid-ramp SHALL discard all progress; no output pulse SHALL be generated by the reset itself.

Configuration
REQ-026 With macro RGB_LED_SEQUENCER_GAMMA_EN defined, the compare value SHALL be (duty_active*duty_active)>>PWM_BITS, a 2*PWM_BITS-bit product truncated.
REQ-027 Without RGB_LED_SEQUENCER_GAMMA_EN, the compare value SHALL be duty_active (linear); FSM timing SHALL be identical in both builds.

Verification
REQ-028 A bench SHALL cover: PWM_BITS=4, STEP=4, HOLD_TICKS=2, enable=1, tick every 16 clks -> duty sequence 0,4,8,12,15; two HOLD ticks; 11,7,3,0; then color=1.
REQ-029 A bench SHALL cover: full R->G->B run with the REQ-028 parameters -> cycle_done exactly one clk at the B-to-R wrap, color back at 0, never 3.
REQ-030 A bench SHALL cover: duty changed mid PWM period with duty=8 -> nLED_RED low for exactly 8 of 16 clks only from the next period boundary.
REQ-031 A bench SHALL cover: enable dropped during RAMP_DOWN -> next clk all nLED high, color=0, state IDLE; re-enable restarts at RED, duty=0.
REQ-032 A bench SHALL cover: rst pulsed low asynchronously between clk edges mid-HOLD -> outputs high before the next edge; after release the ramp restarts from 0.
REQ-033 A bench SHALL cover: build with RGB_LED_SEQUENCER_GAMMA_EN, PWM_BITS=4, duty_active=8 -> LED low 4 of 16 clks; duty_active=15 -> low 14 of 16 clks.
